i2c_target: RTL and testbench

Bus-side I2C target (responder) for closing the loop around the TileLink I2C controller in simulation and formal harnesses. Watches the controller's `scl`/`sda` outputs, decodes START/STOP/address/data, ACKs its own 7-bit address and serves a small byte-wide register file through open-drain SDA. Has a local host port for preloading registers and reporting bus writes.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_bus_monitor.sv | 52 +++++
 rtl/i2c_target.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target.
//   state_t        FSM state encoding
//   COV_*          bit positions inside cover_out (I2C_TARGET_COVER_EN builds)
//   ACK / NACK     SDA levels of the acknowledge bit
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RACK,
        S_IGNORE
    } state_t;

    localparam int NSTATES      = 10;
    localparam int COV_START    = 10;
    localparam int COV_RSTART   = 11;
    localparam int COV_STOP     = 12;
    localparam int COV_MISMATCH = 13;
    localparam int COV_NACK     = 14;
    localparam int COV_WRAP     = 15;
    localparam int COV_W        = 16;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronizes SCL/SDA and produces registered bus events.
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   scl_in, sda_in      raw asynchronous bus levels
//   sda_s               synchronized SDA, aligned with the event pulses
//   start, stop         START / STOP condition pulses (one cycle)
//   scl_rise, scl_fall  SCL edge pulses (one cycle)
// All pulses appear three clocks after the bus change (2 sync + 1 detect).
module i2c_bus_monitor (
    input  logic clock,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Everything resets to the idle-bus level (high) so releasing reset
    // against an idle bus produces no event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            sda_s    <= 1'b1;
            start    <= 1'b0;
            stop     <= 1'b0;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
            sda_s    <= sda_sync[1];
            start    <= scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
            stop     <= scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];
            scl_rise <= scl_sync[1] & ~scl_prev;
            scl_fall <= ~scl_sync[1] & scl_prev;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target that ACKs address ADDR and serves NREGS byte registers.
// Parameters: ADDR (7-bit target address), NREGS (power of two, 2..256).
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   scl_in, sda_in          asynchronous bus levels
//   sda_oe                  1 = pull SDA low
//   host_we/addr/wdata      local register preload port
//   wr_valid/addr/data      one-cycle report of each byte written from the bus
//   busy                    addressed transaction in progress
//   cover_out               coverage points, only with I2C_TARGET_COVER_EN
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | no transaction, waiting for START
// S_ADDR      | shifting in address + R/W
// S_ADDR_ACK  | acknowledging our address
// S_PTR       | shifting in register pointer
// S_PTR_ACK   | acknowledging pointer byte
// S_WDATA     | shifting in a write data byte
// S_WDATA_ACK | acknowledging write data byte
// S_RDATA     | driving regs[ptr] MSB first
// S_RACK      | SDA released, sampling the controller's ACK/NACK
// S_IGNORE    | not addressed or read ended; wait for START/STOP
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR  = 7'h50,
    parameter int         NREGS = 8,
    localparam int        AW    = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
`ifdef I2C_TARGET_COVER_EN
    ,
    output logic [COV_W-1:0] cover_out
`endif
);

    logic sda_s, start, stop, scl_rise, scl_fall;

    i2c_bus_monitor u_mon (
        .clock    (clock),
        .reset_n  (reset_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_s    (sda_s),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [6:0]      shreg_q, shreg_d;
    logic [6:0]      txreg_q, txreg_d;
    logic [AW-1:0]   ptr_q, ptr_d, ptr_nxt;
    logic            oe_q, oe_d;
    logic            phase_q, phase_d;
    logic            mack_q, mack_d;
    logic            rw_q, rw_d;
    logic            busy_q, busy_d;
    logic            wr_valid_q, wr_valid_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            ptr_inc;
    logic [7:0]      byte_in;
    logic [7:0]      rd_cur, rd_nxt;
    logic [7:0]      regs [NREGS];

    assign byte_in = {shreg_q, sda_s};
    assign ptr_nxt = ptr_q + 1'b1;
    assign rd_cur  = regs[ptr_q];
    assign rd_nxt  = regs[ptr_nxt];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            txreg_q    <= '0;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            phase_q    <= 1'b0;
            mack_q     <= NACK;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            txreg_q    <= txreg_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            phase_q    <= phase_d;
            mack_q     <= mack_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // phase_q: in ACK states, 0 = waiting for the fall after bit 8,
    // 1 = ACK being driven. In S_RACK, 1 = controller's ACK bit sampled.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        txreg_d    = txreg_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        phase_d    = phase_q;
        mack_d     = mack_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ptr_inc    = 1'b0;

        if (start) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            oe_d      = 1'b0;
        end else if (stop) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            if (state_q == S_ADDR) begin
                                if (byte_in[7:1] == ADDR) begin
                                    state_d = S_ADDR_ACK;
                                    rw_d    = byte_in[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = S_IGNORE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d   = byte_in[AW-1:0];
                                state_d = S_PTR_ACK;
                            end else begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = byte_in;
                                ptr_inc    = 1'b1;
                                state_d    = S_WDATA_ACK;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            oe_d    = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            oe_d    = 1'b0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                // First read bit goes out on the same fall
                                // that ends the ACK.
                                state_d   = S_RDATA;
                                bit_cnt_d = '0;
                                txreg_d   = rd_cur[6:0];
                                oe_d      = ~rd_cur[7];
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = S_RACK;
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            oe_d      = 1'b0;
                        end else begin
                            txreg_d = {txreg_q[5:0], 1'b0};
                            oe_d    = ~txreg_q[6];
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        phase_d = 1'b1;
                        mack_d  = sda_s;
                    end else if (scl_fall && phase_q) begin
                        phase_d = 1'b0;
                        if (mack_q == ACK) begin
                            ptr_inc   = 1'b1;
                            state_d   = S_RDATA;
                            bit_cnt_d = '0;
                            txreg_d   = rd_nxt[6:0];
                            oe_d      = ~rd_nxt[7];
                        end else begin
                            state_d = S_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (ptr_inc) ptr_d = ptr_nxt;
    end

    always_comb begin
        sda_oe   = oe_q;
        busy     = busy_q;
        wr_valid = wr_valid_q;
        wr_addr  = wr_addr_q;
        wr_data  = wr_data_q;
    end

    // A bus commit and a host write to the same index land together:
    // the bus byte is kept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (host_we && !(wr_valid_q && (wr_addr_q == host_addr)))
                regs[host_addr] <= host_wdata;
            if (wr_valid_q)
                regs[wr_addr_q] <= wr_data_q;
        end
    end

`ifdef I2C_TARGET_COVER_EN
    logic [COV_W-1:NSTATES] cov_ev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cov_ev_q <= '0;
        end else begin
            cov_ev_q[COV_START]    <= start;
            cov_ev_q[COV_RSTART]   <= start && (state_q != S_IDLE);
            cov_ev_q[COV_STOP]     <= stop;
            cov_ev_q[COV_MISMATCH] <= !start && !stop && scl_rise && (state_q == S_ADDR)
                                      && (bit_cnt_q == 4'd7) && (byte_in[7:1] != ADDR);
            cov_ev_q[COV_NACK]     <= !start && !stop && scl_fall && (state_q == S_RACK)
                                      && phase_q && (mack_q == NACK);
            cov_ev_q[COV_WRAP]     <= ptr_inc && (ptr_q == AW'(NREGS - 1));
        end
    end

    always_comb begin
        cover_out                  = '0;
        cover_out[NSTATES-1:0]     = NSTATES'(1) << state_q;
        cover_out[COV_W-1:NSTATES] = cov_ev_q;
    end
`endif

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int T  = 10;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          scl_m, sda_m;
    logic          sda_in;
    logic          sda_oe;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
`ifdef I2C_TARGET_COVER_EN
    logic [COV_W-1:0] cover_out;
    logic             cov_rs, cov_wrap;
`endif

    always #5 clock = ~clock;

    // Open-drain bus: either side can pull SDA low.
    assign sda_in = sda_m & ~sda_oe;

    i2c_target dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .scl_in     (scl_m),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
`ifdef I2C_TARGET_COVER_EN
        ,
        .cover_out  (cover_out)
`endif
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         wr_cnt   = 0;
    logic [7:0] last_wr_data;
    logic [2:0] last_wr_addr;
    logic       oe_seen;

    always @(negedge clock) begin
        if (wr_valid) begin
            wr_cnt++;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (sda_oe) oe_seen = 1'b1;
`ifdef I2C_TARGET_COVER_EN
        if (cover_out[COV_RSTART]) cov_rs = 1'b1;
        if (cover_out[COV_WRAP])   cov_wrap = 1'b1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic phase();
        repeat (T) @(negedge clock);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; phase();
        scl_m = 1'b1; phase();
        sda_m = 1'b0; phase();
        scl_m = 1'b0; phase();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; phase();
        scl_m = 1'b1; phase();
        sda_m = 1'b1; phase();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; phase();
            scl_m = 1'b1; phase();
            scl_m = 1'b0; phase();
        end
        sda_m = 1'b1; phase();
        scl_m = 1'b1; phase();
        ack = sda_in;
        scl_m = 1'b0; phase();
    endtask

    task automatic read_byte(input logic ack_out, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            phase();
            scl_m = 1'b1; phase();
            d[i] = sda_in;
            scl_m = 1'b0;
        end
        sda_m = ack_out; phase();
        scl_m = 1'b1; phase();
        scl_m = 1'b0; phase();
        sda_m = 1'b1;
    endtask

    task automatic host_write(input logic [AW-1:0] idx, input logic [7:0] d);
        @(negedge clock);
        host_we = 1'b1; host_addr = idx; host_wdata = d;
        @(negedge clock);
        host_we = 1'b0;
    endtask

    // Drives a host write in the very cycle the bus commit is reported.
    task automatic collide(input logic [AW-1:0] idx, input logic [7:0] d, output logic hit);
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (wr_valid) begin
                host_we = 1'b1; host_addr = idx; host_wdata = d;
                @(negedge clock);
                host_we = 1'b0;
                hit = 1'b1;
                break;
            end
        end
    endtask

    logic       ack, hit;
    logic [7:0] rd;
    int         cnt0;
    logic [7:0] exp_rd [5] = '{8'h22, 8'h33, 8'h00, 8'h00, 8'h66};

    initial begin
        reset_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        oe_seen = 1'b0;
`ifdef I2C_TARGET_COVER_EN
        cov_rs = 1'b0; cov_wrap = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // Plain write: A0, pointer 3, data A5
        bus_start();
        write_byte(8'hA0, ack); check("s1_ack_addr", ack, ACK);
        write_byte(8'h03, ack); check("s1_ack_ptr", ack, ACK);
        write_byte(8'hA5, ack); check("s1_ack_data", ack, ACK);
        check("s1_busy", busy, 1);
        check("s1_wr_cnt", wr_cnt, 1);
        check("s1_wr_addr", last_wr_addr, 3);
        check("s1_wr_data", last_wr_data, 8'hA5);
        bus_stop();
        phase();
        check("s1_busy_stop", busy, 0);

        // Pointer write, repeated START, two reads wrapping 7 -> 0
        host_write(3'd7, 8'h3C);
        host_write(3'd0, 8'hC3);
`ifdef I2C_TARGET_COVER_EN
        cov_rs = 1'b0; cov_wrap = 1'b0;
`endif
        bus_start();
        write_byte(8'hA0, ack); check("s2_ack_addr", ack, ACK);
        write_byte(8'h07, ack); check("s2_ack_ptr", ack, ACK);
        bus_start();
        write_byte(8'hA1, ack); check("s2_ack_raddr", ack, ACK);
        read_byte(ACK, rd);  check("s2_rd0", rd, 8'h3C);
        read_byte(NACK, rd); check("s2_rd1", rd, 8'hC3);
        phase();
        check("s2_oe_after_nack", sda_oe, 0);
        check("s2_busy_after_nack", busy, 0);
        bus_stop();
`ifdef I2C_TARGET_COVER_EN
        check("s2_cov_rstart", cov_rs, 1);
        check("s2_cov_wrap", cov_wrap, 1);
`endif

        // Foreign address 0x28 is never acknowledged
        cnt0 = wr_cnt;
        bus_start();
        oe_seen = 1'b0;
        write_byte(8'h51, ack); check("s3_nack_addr", ack, NACK);
        write_byte(8'h00, ack); check("s3_nack_data", ack, NACK);
        check("s3_busy", busy, 0);
        bus_stop();
        check("s3_oe_never", oe_seen, 0);
        check("s3_no_wr", wr_cnt, cnt0);

        // Reset while the target is pulling SDA low for a 0 data bit
        host_write(3'd4, 8'h00);
        bus_start();
        write_byte(8'hA0, ack); check("s4_ack_addr", ack, ACK);
        write_byte(8'h04, ack); check("s4_ack_ptr", ack, ACK);
        bus_start();
        write_byte(8'hA1, ack); check("s4_ack_raddr", ack, ACK);
        phase();
        check("s4_oe_driving", sda_oe, 1);
        reset_n = 1'b0;
        #1;
        check("s4_oe_async_rel", sda_oe, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        cnt0 = wr_cnt;
        oe_seen = 1'b0;
        write_byte(8'hA0, ack); check("s4_post_rst_nack", ack, NACK);
        write_byte(8'h5A, ack);
        check("s4_oe_quiet", oe_seen, 0);
        check("s4_no_wr", wr_cnt, cnt0);
        check("s4_busy", busy, 0);
        bus_stop();

        // Same-cycle host writes: idx 2 collides (bus wins), idx 6 does not
        bus_start();
        write_byte(8'hA0, ack); check("s5_ack_addr", ack, ACK);
        write_byte(8'h02, ack); check("s5_ack_ptr", ack, ACK);
        fork
            write_byte(8'h22, ack);
            collide(3'd2, 8'h11, hit);
        join
        check("s5_collide_hit0", hit, 1);
        fork
            write_byte(8'h33, ack);
            collide(3'd6, 8'h66, hit);
        join
        check("s5_collide_hit1", hit, 1);
        check("s5_wr_addr", last_wr_addr, 3);
        check("s5_wr_data", last_wr_data, 8'h33);
        bus_stop();
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        bus_start();
        write_byte(8'hA1, ack); check("s5_ack_raddr", ack, ACK);
        for (int i = 0; i < 5; i++) begin
            read_byte((i == 4) ? NACK : ACK, rd);
            check($sformatf("s5_rd%0d", i), rd, exp_rd[i]);
        end
        bus_stop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
